// File: rtl/write_back.sv
// Write-back stage: picks one completed result per cycle from the CSR, ALU
// and LSU queues, writes it to the register file and signals a retire. A CSR
// exception or mret entry starts a flush that redirects PC Control and drains
// every queue for FLUSH_CYCLES cycles.
module write_back #(
    parameter int xlen         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_v,
    input  logic [xlen-1:0] alu_result,
    input  logic [4:0]      alu_rd,
    output logic            alu_ok,
    input  logic            lsu_v,
    input  logic [xlen-1:0] lsu_result,
    input  logic [4:0]      lsu_rd,
    output logic            lsu_ok,
    input  logic            csr_v,
    input  logic [xlen-1:0] csr_result,
    input  logic [4:0]      csr_rd,
    input  logic            csr_exception,
    input  logic [xlen-1:0] csr_target,
    output logic            csr_ok,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [xlen-1:0] rf_wdata,
    output logic            instret_v,
    output logic            flush,
    output logic [xlen-1:0] target
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // rr_ptr: 0 means ALU has priority next, 1 means LSU has priority next
    localparam logic RR_ALU = 1'b0;
    localparam logic RR_LSU = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            rr_ptr, rr_nxt;
    logic            gnt_alu, gnt_lsu, gnt_csr;
    logic            rf_we_nxt, instret_nxt, flush_nxt;
    logic [4:0]      rf_rd_nxt;
    logic [xlen-1:0] rf_wdata_nxt, target_nxt;

    // Arbitration, dequeue handshakes and next values of the registered outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rr_nxt       = rr_ptr;
        gnt_csr      = 1'b0;
        gnt_alu      = 1'b0;
        gnt_lsu      = 1'b0;
        alu_ok       = 1'b0;
        lsu_ok       = 1'b0;
        csr_ok       = 1'b0;
        rf_we_nxt    = 1'b0;
        rf_rd_nxt    = rf_rd;
        rf_wdata_nxt = rf_wdata;
        instret_nxt  = 1'b0;
        flush_nxt    = flush;
        target_nxt   = target;

        case (state)
            RUN: begin
                flush_nxt = 1'b0;
                // CSR always first; ALU/LSU share by round-robin, and a lone
                // valid source wins regardless of the pointer.
                gnt_csr = csr_v;
                gnt_alu = !csr_v && alu_v && (!lsu_v || rr_ptr == RR_ALU);
                gnt_lsu = !csr_v && lsu_v && (!alu_v || rr_ptr == RR_LSU);
                csr_ok  = gnt_csr;
                alu_ok  = gnt_alu;
                lsu_ok  = gnt_lsu;

                if (gnt_csr) begin
                    if (csr_exception) begin
                        state_nxt  = FLUSH;
                        cnt_nxt    = CNT_LOAD;
                        flush_nxt  = 1'b1;
                        target_nxt = csr_target;
                    end else begin
                        instret_nxt = 1'b1;
                        if (csr_rd != 5'd0) begin
                            rf_we_nxt    = 1'b1;
                            rf_rd_nxt    = csr_rd;
                            rf_wdata_nxt = csr_result;
                        end
                    end
                end else if (gnt_alu) begin
                    rr_nxt      = RR_LSU;
                    instret_nxt = 1'b1;
                    if (alu_rd != 5'd0) begin
                        rf_we_nxt    = 1'b1;
                        rf_rd_nxt    = alu_rd;
                        rf_wdata_nxt = alu_result;
                    end
                end else if (gnt_lsu) begin
                    rr_nxt      = RR_ALU;
                    instret_nxt = 1'b1;
                    if (lsu_rd != 5'd0) begin
                        rf_we_nxt    = 1'b1;
                        rf_rd_nxt    = lsu_rd;
                        rf_wdata_nxt = lsu_result;
                    end
                end
            end

            FLUSH: begin
                // Drain: every queue is popped and its entry thrown away
                alu_ok    = 1'b1;
                lsu_ok    = 1'b1;
                csr_ok    = 1'b1;
                flush_nxt = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = RUN;
                    flush_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            default: begin
                state_nxt = RUN;
                flush_nxt = 1'b0;
            end
        endcase
    end

    // State, flush counter, round-robin pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= 4'd0;
            rr_ptr    <= RR_ALU;
            rf_we     <= 1'b0;
            rf_rd     <= 5'd0;
            rf_wdata  <= '0;
            instret_v <= 1'b0;
            flush     <= 1'b0;
            target    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rr_ptr    <= rr_nxt;
            rf_we     <= rf_we_nxt;
            rf_rd     <= rf_rd_nxt;
            rf_wdata  <= rf_wdata_nxt;
            instret_v <= instret_nxt;
            flush     <= flush_nxt;
            target    <= target_nxt;
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: arbitration order, retire timing, rd=0
// handling, flush length/drain and asynchronous reset during a flush.
module tb_write_back;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_v, lsu_v, csr_v, csr_exception;
    logic [XLEN-1:0] alu_result, lsu_result, csr_result, csr_target;
    logic [4:0]      alu_rd, lsu_rd, csr_rd;
    logic            alu_ok, lsu_ok, csr_ok;
    logic            rf_we, instret_v, flush;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata, target;

    int n_chk = 0;
    int n_err = 0;

    write_back #(.xlen(XLEN), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_v(alu_v), .alu_result(alu_result), .alu_rd(alu_rd), .alu_ok(alu_ok),
        .lsu_v(lsu_v), .lsu_result(lsu_result), .lsu_rd(lsu_rd), .lsu_ok(lsu_ok),
        .csr_v(csr_v), .csr_result(csr_result), .csr_rd(csr_rd),
        .csr_exception(csr_exception), .csr_target(csr_target), .csr_ok(csr_ok),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .instret_v(instret_v), .flush(flush), .target(target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock edge and land 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alu_v = 1'b0; lsu_v = 1'b0; csr_v = 1'b0; csr_exception = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_ok(input string tag, input logic a, input logic l, input logic c);
        chk({tag, "_alu_ok"}, alu_ok, a);
        chk({tag, "_lsu_ok"}, lsu_ok, l);
        chk({tag, "_csr_ok"}, csr_ok, c);
    endtask

    task automatic chk_retire(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, rf_we, 1'b1);
        chk({tag, "_rd"}, rf_rd, rd);
        chk({tag, "_wdata"}, rf_wdata, d);
        chk({tag, "_instret"}, instret_v, 1'b1);
    endtask

    initial begin
        alu_result = '0; lsu_result = '0; csr_result = '0; csr_target = '0;
        alu_rd = '0; lsu_rd = '0; csr_rd = '0;
        alu_v = 1'b0; lsu_v = 1'b0; csr_v = 1'b0; csr_exception = 1'b0;
        rst_n = 1'b0;
        #3;
        // reset state
        chk("rst_we", rf_we, 1'b0);
        chk("rst_rd", rf_rd, 5'd0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_instret", instret_v, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_target", target, 32'h0);
        chk_ok("rst", 1'b0, 1'b0, 1'b0);
        do_reset();

        // 1: single ALU retire with one-cycle latency
        alu_v = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234;
        #1 chk_ok("t1", 1'b1, 1'b0, 1'b0);
        tick();
        alu_v = 1'b0;
        chk_retire("t1", 5'd5, 32'h1234);
        tick();
        chk("t1_we_after", rf_we, 1'b0);
        chk("t1_instret_after", instret_v, 1'b0);

        // 2: ALU and LSU both valid -> alternate starting with ALU
        do_reset();
        alu_v = 1'b1; alu_rd = 5'd1; alu_result = 32'h11;
        lsu_v = 1'b1; lsu_rd = 5'd2; lsu_result = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1 chk_ok($sformatf("t2_c%0d", i), (i % 2) == 0, (i % 2) == 1, 1'b0);
            tick();
            if (i % 2 == 0) chk_retire($sformatf("t2_r%0d", i), 5'd1, 32'h11);
            else            chk_retire($sformatf("t2_r%0d", i), 5'd2, 32'h22);
        end
        alu_v = 1'b0; lsu_v = 1'b0;
        tick();
        chk("t2_idle_instret", instret_v, 1'b0);

        // 3: all three valid, no exception -> CSR, then ALU, then LSU
        csr_v = 1'b1; csr_rd = 5'd3; csr_result = 32'h33; csr_exception = 1'b0;
        alu_v = 1'b1; lsu_v = 1'b1;
        #1 chk_ok("t3_c0", 1'b0, 1'b0, 1'b1);
        tick();
        csr_v = 1'b0;
        chk_retire("t3_csr", 5'd3, 32'h33);
        #1 chk_ok("t3_c1", 1'b1, 1'b0, 1'b0);
        tick();
        alu_v = 1'b0;
        chk_retire("t3_alu", 5'd1, 32'h11);
        #1 chk_ok("t3_c2", 1'b0, 1'b1, 1'b0);
        tick();
        lsu_v = 1'b0;
        chk_retire("t3_lsu", 5'd2, 32'h22);

        // 4: rd=0 retires without a write
        alu_v = 1'b1; alu_rd = 5'd0; alu_result = 32'hFFFF;
        tick();
        alu_v = 1'b0;
        chk("t4_we", rf_we, 1'b0);
        chk("t4_instret", instret_v, 1'b1);

        // 5: exception -> 2-cycle flush draining ALU, then ALU retires
        alu_v = 1'b1; alu_rd = 5'd1; alu_result = 32'h55;
        csr_v = 1'b1; csr_exception = 1'b1; csr_target = 32'h8000_0100;
        #1 chk_ok("t5_exc", 1'b0, 1'b0, 1'b1);
        tick();
        csr_v = 1'b0; csr_exception = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5_flush%0d", i), flush, 1'b1);
            chk($sformatf("t5_target%0d", i), target, 32'h8000_0100);
            chk($sformatf("t5_we%0d", i), rf_we, 1'b0);
            chk($sformatf("t5_instret%0d", i), instret_v, 1'b0);
            chk_ok($sformatf("t5_drain%0d", i), 1'b1, 1'b1, 1'b1);
            tick();
        end
        chk("t5_flush_end", flush, 1'b0);
        chk("t5_we_end", rf_we, 1'b0);
        chk_ok("t5_run", 1'b1, 1'b0, 1'b0);
        tick();
        alu_v = 1'b0;
        chk_retire("t5_post", 5'd1, 32'h55);

        // 6: async reset during the first flush cycle
        csr_v = 1'b1; csr_exception = 1'b1; csr_target = 32'h8000_0200;
        tick();
        csr_v = 1'b0; csr_exception = 1'b0;
        chk("t6_flush_on", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_flush_async", flush, 1'b0);
        chk("t6_target_async", target, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        alu_v = 1'b1; alu_rd = 5'd7; alu_result = 32'hABCD;
        #1 chk_ok("t6_run", 1'b1, 1'b0, 1'b0);
        tick();
        alu_v = 1'b0;
        chk_retire("t6_post", 5'd7, 32'hABCD);
        chk("t6_flush_post", flush, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Write-back stage of the intirvx core.
- Consumes completed results from the ALU, LSU and CSR pipelines through ready/valid FIFO dequeue handshakes.
- Arbitrates one result per cycle into the register file and pulses instret_v back to the CSR unit.
- On a CSR exception or mret, redirects PC Control with a flush sequence.

Parameters:
- xlen, 32: data/address width; taken from cpu_parameters.
- FLUSH_CYCLES, 2: cycles flush stays asserted after a redirect; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_v  in  1  ALU result valid.
- alu_result  in  xlen  ALU result data.
- alu_rd  in  5  ALU destination register.
- alu_ok  out  1  ALU dequeue ready.
- lsu_v  in  1  LSU result valid.
- lsu_result  in  xlen  LSU load data.
- lsu_rd  in  5  LSU destination register.
- lsu_ok  out  1  LSU dequeue ready.
- csr_v  in  1  CSR result valid.
- csr_result  in  xlen  old CSR value.
- csr_rd  in  5  CSR destination register.
- csr_exception  in  1  CSR entry is an exception or mret.
- csr_target  in  xlen  redirect PC for an exception entry.
- csr_ok  out  1  CSR dequeue ready.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_wdata  out  xlen  register-file write data.
- instret_v  out  1  one-cycle pulse per retired instruction.
- flush  out  1  pipeline flush to all FIFOs and PC Control.
- target  out  xlen  redirect PC; valid while flush=1.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=RUN, rr_ptr=ALU, flush counter=0.
- Clock and reset names: clk and rst_n; reset is asynchronous, active-low.
- All outputs except *_ok are registered. Latency is 1 cycle: an entry accepted at edge N appears on rf_*/instret_v/flush in cycle N+1.
- Accept rule: a source's entry is consumed on a cycle where x_v && x_ok.
- At most one of alu_ok, lsu_ok, csr_ok is 1 in RUN. All three are 1 in FLUSH (drain).
- RUN arbitration (combinational from *_v and rr_ptr):
  - csr_v wins unconditionally.
  - Otherwise round-robin between ALU and LSU.
  - rr_ptr toggles to the other source only when an ALU/LSU grant is accepted.
  - If only one of alu_v/lsu_v is set, that source wins regardless of rr_ptr.
  - No valid source: all ok=0.
- Normal retire (granted entry with csr_exception=0):
  - Next cycle: rf_we = (rd != 0), rf_rd = rd, rf_wdata = result, instret_v = 1.
  - rd=0 retires with no write: rf_we=0, instret_v=1.
- Exception retire (CSR grant with csr_exception=1):
  - No register write; instret_v=0.
  - Next cycle: flush=1, target=csr_target.
  - FSM -> FLUSH; counter loads FLUSH_CYCLES-1.
- FLUSH state:
  - flush=1, target held stable, rf_we=0, instret_v=0.
  - All ok=1; any valid input is discarded, not retired.
  - Counter decrements each cycle. At 0, FSM -> RUN and flush deasserts the following cycle.
  - flush is high for exactly FLUSH_CYCLES consecutive cycles.
- Back-to-back retires: one retire per cycle sustained; no bubble between grants.
- Simultaneous valids: csr_v, alu_v and lsu_v all 1 with no exception -> CSR retires first, then ALU/LSU in round-robin order.
- Reset mid-FLUSH: flush drops asynchronously to 0; FSM=RUN.
- rf_rd/rf_wdata hold their last value when rf_we=0; the bench must not check them then.

Test Plan:
1. After reset, alu_v=1, alu_rd=5, alu_result=0x1234 for one cycle -> alu_ok=1 the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234, instret_v=1; following cycle rf_we=0.
2. alu_v and lsu_v held at 1 for 4 cycles, rd=1 and rd=2 -> grants alternate ALU, LSU, ALU, LSU; rf_rd sequence 1,2,1,2; instret_v=1 on 4 consecutive cycles.
3. csr_v, alu_v and lsu_v all 1 with csr_exception=0, csr_rd=3 -> CSR retires first (rf_rd=3); ALU and LSU follow in the next two cycles.
4. ALU entry with alu_rd=0, result 0xFFFF -> rf_we=0, instret_v=1.
5. csr_v=1, csr_exception=1, csr_target=0x80000100, alu_v held at 1 -> next cycle flush=1, target=0x80000100 for exactly 2 cycles; alu_ok=1 and no rf_we/instret_v during flush; ALU retires normally after flush deasserts.
6. rst_n pulsed low during the first flush cycle -> flush=0 immediately; after release, the next alu_v retires with 1-cycle latency.
